router_input_unit: RTL and testbench
====================================

Name: router_input_unit

Overview:
- Buffered, parametrised successor to the combinational router input control.
- Sits at each router input port:
  - accepts flits into a FIFO of depth p_depth;
  - computes the route of the head flit (pass-through or shortest-path ring mode);
  - raises a one-hot output-port request;
  - locks the chosen port for multi-flit packets (wormhole) until the tail flit departs.

Parameters:
p_router_id, 0, this router's id
p_num_routers, 8, routers on the ring
p_msg_nbits, 32, flit width
p_dest_lsb, 0, LSB of dest field in flit
p_depth, 4, FIFO entries (power of 2, >=2)
p_num_ports, 3, output ports (=3 when p_route_mode=1)
p_term_port, 1, terminal port index
p_default_port, 0, port used in pass-through mode
p_route_mode, 0, 0=pass-through, 1=shortest-path ring (port 0=west/ccw, 2=east/cw)
c_dest_nbits, $clog2(p_num_routers), derived
c_cnt_nbits, $clog2(p_depth)+1, derived

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
in_val  in  1  input flit valid
in_rdy  out  1  input ready
in_msg  in  p_msg_nbits  input flit
in_tail  in  1  flit is last of packet (single-flit packet: head=tail)
out_msg  out  p_msg_nbits  FIFO head flit
out_tail  out  1  tail bit of head flit
reqs  out  p_num_ports  one-hot port request
grants  in  p_num_ports  one-hot grants from output arbiters
count  out  c_cnt_nbits  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - count=0, lock cleared, reqs=0;
  - in_rdy forced 0 while reset is low;
  - out_msg/out_tail don't-care.
- Enqueue when in_val & in_rdy; in_rdy = (count != p_depth). No bypass: a flit enqueued in cycle t can request no earlier than t+1.
- Dequeue ("depart") when |(reqs & grants).
  - Grant bits on unrequested ports are ignored.
  - Simultaneous enq+deq keeps count unchanged, including when count=p_depth-1.
  - At full, in_rdy=0 even if a departure occurs that cycle; there is no full-bypass.
- Pointers wrap modulo p_depth.
- count never exceeds p_depth and never underflows.
- Empty FIFO: reqs=0.
- Route of head (dest = out_msg[p_dest_lsb +: c_dest_nbits]):
  - dest==p_router_id -> p_term_port (both modes).
  - Mode 0: else p_default_port.
  - Mode 1: cw=(dest-id) mod N, ccw=(id-dest) mod N, c_dest_nbits+1-bit arithmetic; cw<=ccw -> port 2 (east), else port 0 (west). Ties go east.
- Lock FSM, states IDLE/LOCKED:
  - IDLE: reqs = one-hot(route) if nonempty.
    - Departure of a non-tail flit -> LOCKED, lock_port = route.
    - Departure of a tail flit -> stay IDLE.
  - LOCKED: reqs = one-hot(lock_port) if nonempty, regardless of dest field in body flits.
    - Departure of a tail flit -> IDLE.
  - Empty in LOCKED: reqs=0 and remain LOCKED.
- reqs is combinational from FIFO head and lock state. It holds stable until departure; arbiter fairness is not this block's concern.
- Reset mid-packet: lock and FIFO cleared immediately; partial packet dropped.

Test Plan:
- Reset then 1-flit packet, dest=0, id=0, mode 0: enq at t -> reqs=3'b010 at t+1; grants=3'b010 -> count 1->0, reqs=0 next cycle.
- Mode 0, dest=5, id=0: reqs=3'b001. With grants=3'b100, no departure and count stays 1.
- Mode 1, N=8, id=2: dest=5 -> 3'b100; dest=7 -> 3'b001; dest=6 (tie, cw=ccw=4) -> 3'b100.
- 3-flit packet: head dest=5 (east, id=2), body dest fields=2. Body flits still request 3'b100. After tail departs, next head dest=2 -> 3'b010.
- Fill with grants=0: 4 flits accepted, in_rdy=0, count=4. Then in_val=1 and grant held: count stays at 4 with in_rdy=0, drops to 3. Steady enq+deq keeps count=3.
- Assert reset while LOCKED with count=2: count=0, reqs=0 and in_rdy=0 immediately. After release, a new head routes freshly.

Source files
------------

// File: rtl/router_input_unit.sv
// Router input port: flit FIFO, head-flit route computation and wormhole port lock.
// reqs is combinational from the FIFO head and the lock state; a departure is any granted request.
//
// state  | meaning
// IDLE   | no packet in flight; head flit requests its own computed route
// LOCKED | packet body in flight; every flit requests lock_port until the tail departs
module router_input_unit #(
    parameter int p_router_id    = 0,
    parameter int p_num_routers  = 8,
    parameter int p_msg_nbits    = 32,
    parameter int p_dest_lsb     = 0,
    parameter int p_depth        = 4,
    parameter int p_num_ports    = 3,
    parameter int p_term_port    = 1,
    parameter int p_default_port = 0,
    parameter int p_route_mode   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [p_msg_nbits-1:0]     in_msg,
    input  logic                       in_tail,
    output logic [p_msg_nbits-1:0]     out_msg,
    output logic                       out_tail,
    output logic [p_num_ports-1:0]     reqs,
    input  logic [p_num_ports-1:0]     grants,
    output logic [$clog2(p_depth):0]   count
);
    localparam int c_dest_nbits = (p_num_routers > 1) ? $clog2(p_num_routers) : 1;
    localparam int c_cnt_nbits  = $clog2(p_depth) + 1;
    localparam int c_ptr_nbits  = $clog2(p_depth);
    localparam int c_port_nbits = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [c_dest_nbits:0]   c_id      = (c_dest_nbits+1)'(p_router_id);
    localparam logic [c_dest_nbits:0]   c_n       = (c_dest_nbits+1)'(p_num_routers);
    localparam logic [c_port_nbits-1:0] c_term    = c_port_nbits'(p_term_port);
    localparam logic [c_port_nbits-1:0] c_default = c_port_nbits'(p_default_port);
    localparam logic [c_port_nbits-1:0] c_east    = c_port_nbits'(2);
    localparam logic [c_cnt_nbits-1:0]  c_full    = c_cnt_nbits'(p_depth);

    logic [p_msg_nbits:0]      mem [p_depth];
    logic [c_ptr_nbits-1:0]    wr_ptr;
    logic [c_ptr_nbits-1:0]    rd_ptr;
    logic                      enq;
    logic                      deq;
    logic                      empty;

    logic [0:0]                state;
    logic [c_port_nbits-1:0]   lock_port;
    logic [c_port_nbits-1:0]   route;
    logic [c_port_nbits-1:0]   sel_port;
    logic [c_dest_nbits-1:0]   dest;
    logic [c_dest_nbits:0]     dest_w;
    logic [c_dest_nbits:0]     cw;
    logic [c_dest_nbits:0]     ccw;

    // in_rdy is gated by reset itself so it drops the moment reset asserts.
    assign in_rdy = reset & (count != c_full);
    assign enq    = in_val & in_rdy;
    assign empty  = (count == '0);
    assign deq    = |(reqs & grants);
    assign {out_tail, out_msg} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {in_tail, in_msg};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dest = out_msg[p_dest_lsb +: c_dest_nbits];

    // Ring distances kept one bit wider so dest + N - id cannot overflow.
    always_comb begin
        dest_w = {1'b0, dest};
        cw     = (dest_w >= c_id) ? (dest_w - c_id) : (dest_w + c_n - c_id);
        ccw    = (c_id >= dest_w) ? (c_id - dest_w) : (c_id + c_n - dest_w);
        if (dest_w == c_id) begin
            route = c_term;
        end else if (p_route_mode == 0) begin
            route = c_default;
        end else if (cw <= ccw) begin
            route = c_east;
        end else begin
            route = '0;
        end
    end

    assign sel_port = (state == LOCKED) ? lock_port : route;

    always_comb begin
        reqs = '0;
        if (!empty) begin
            reqs[sel_port] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lock_port <= '0;
        end else if (deq) begin
            case (state)
                IDLE: begin
                    if (!out_tail) begin
                        state     <= LOCKED;
                        lock_port <= route;
                    end
                end
                LOCKED: begin
                    if (out_tail) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit: one pass-through instance (id 0) and one ring instance (id 2).
module tb_router_input_unit;
    logic        clk;
    logic        rst;

    logic        v0, r0, t0, ot0;
    logic [31:0] m0, om0;
    logic [2:0]  q0, g0;
    logic [2:0]  c0;

    logic        v1, r1, t1, ot1;
    logic [31:0] m1, om1;
    logic [2:0]  q1, g1;
    logic [2:0]  c1;

    int checks = 0;
    int errors = 0;

    router_input_unit #(.p_router_id(0), .p_route_mode(0)) u_dut0 (
        .clk(clk), .reset(rst), .in_val(v0), .in_rdy(r0), .in_msg(m0), .in_tail(t0),
        .out_msg(om0), .out_tail(ot0), .reqs(q0), .grants(g0), .count(c0)
    );

    router_input_unit #(.p_router_id(2), .p_route_mode(1)) u_dut1 (
        .clk(clk), .reset(rst), .in_val(v1), .in_rdy(r1), .in_msg(m1), .in_tail(t1),
        .out_msg(om1), .out_tail(ot1), .reqs(q1), .grants(g1), .count(c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        v0 = 0; t0 = 0; m0 = '0; g0 = '0;
        v1 = 0; t1 = 0; m1 = '0; g1 = '0;
        #1;
        chk("rst_count0", c0, 0);
        chk("rst_rdy0",   r0, 0);
        chk("rst_reqs0",  q0, 0);
        chk("rst_count1", c1, 0);
        chk("rst_rdy1",   r1, 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_after_rst", r0, 1);

        // single-flit packet to self, pass-through mode
        v0 = 1; m0 = 32'd0; t0 = 1;
        #1;
        chk("no_bypass_reqs", q0, 3'b000);
        tick();
        v0 = 0;
        #1;
        chk("t1_count", c0, 1);
        chk("t1_reqs_term", q0, 3'b010);
        chk("t1_tail", ot0, 1);
        g0 = 3'b010;
        tick();
        g0 = 3'b000;
        #1;
        chk("t1_count_after_dep", c0, 0);
        chk("t1_reqs_empty", q0, 3'b000);

        // pass-through default port; grant on wrong port ignored
        v0 = 1; m0 = 32'd5; t0 = 1;
        tick();
        v0 = 0;
        g0 = 3'b100;
        #1;
        chk("t2_reqs_default", q0, 3'b001);
        tick();
        chk("t2_count_wrong_grant", c0, 1);
        g0 = 3'b001;
        tick();
        g0 = 3'b000;
        #1;
        chk("t2_count_dep", c0, 0);

        // ring routing from id 2
        v1 = 1; t1 = 1; m1 = 32'd5;
        tick();
        m1 = 32'd7;
        tick();
        m1 = 32'd6;
        tick();
        v1 = 0;
        #1;
        chk("t3_count", c1, 3);
        chk("t3_dest5_east", q1, 3'b100);
        g1 = 3'b100;
        tick();
        g1 = 3'b000;
        #1;
        chk("t3_dest7_west", q1, 3'b001);
        g1 = 3'b001;
        tick();
        g1 = 3'b000;
        #1;
        chk("t3_dest6_tie_east", q1, 3'b100);
        g1 = 3'b100;
        tick();
        g1 = 3'b000;
        #1;
        chk("t3_empty_count", c1, 0);
        chk("t3_empty_reqs", q1, 3'b000);

        // 3-flit wormhole packet followed by a single-flit packet to self
        v1 = 1; m1 = 32'd5; t1 = 0;
        tick();
        m1 = 32'd2; t1 = 0;
        tick();
        m1 = 32'd2; t1 = 1;
        tick();
        m1 = 32'd2; t1 = 1;
        tick();
        v1 = 0;
        #1;
        chk("t4_full_count", c1, 4);
        chk("t4_full_rdy", r1, 0);
        chk("t4_head_east", q1, 3'b100);
        g1 = 3'b100;
        tick();
        chk("t4_body_locked", q1, 3'b100);
        chk("t4_count3", c1, 3);
        tick();
        chk("t4_tail_locked", q1, 3'b100);
        chk("t4_tail_bit", ot1, 1);
        chk("t4_count2", c1, 2);
        tick();
        g1 = 3'b000;
        #1;
        chk("t4_next_head_term", q1, 3'b010);
        chk("t4_count1", c1, 1);
        g1 = 3'b010;
        tick();
        g1 = 3'b000;
        #1;
        chk("t4_drained", c1, 0);

        // fill, then departure at full, then steady enq+deq
        v0 = 1; m0 = 32'd0; t0 = 1;
        tick(); tick(); tick(); tick();
        chk("t5_full_count", c0, 4);
        chk("t5_full_rdy", r0, 0);
        g0 = 3'b010;
        #1;
        chk("t5_full_rdy_with_dep", r0, 0);
        tick();
        chk("t5_count_drop", c0, 3);
        chk("t5_rdy_again", r0, 1);
        tick();
        chk("t5_steady1", c0, 3);
        tick();
        chk("t5_steady2", c0, 3);
        v0 = 0; g0 = 3'b000;

        // reset mid-packet while locked
        v1 = 1; m1 = 32'd5; t1 = 0;
        tick();
        m1 = 32'd2;
        tick();
        tick();
        v1 = 0;
        g1 = 3'b100;
        tick();
        g1 = 3'b000;
        #1;
        chk("t6_locked_count", c1, 2);
        chk("t6_locked_reqs", q1, 3'b100);
        rst = 1'b0;
        #1;
        chk("t6_rst_count", c1, 0);
        chk("t6_rst_reqs", q1, 3'b000);
        chk("t6_rst_rdy", r1, 0);
        @(negedge clk);
        rst = 1'b1;
        v1 = 1; m1 = 32'd7; t1 = 1;
        tick();
        v1 = 0;
        #1;
        chk("t6_fresh_route_west", q1, 3'b001);
        chk("t6_fresh_count", c1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
